mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute over the shared ALU, register file and
//  unified memory. Drives datapath mux selects, write strobes and the 2-bit alu_operation that feeds ALU-control decode.
//  Adds a memory handshake (mem_req/mem_ready), a retired-instruction counter and a sticky illegal-opcode trap.
// PARAMETERS
//  OPCODE_W  6   instruction opcode field width
//  CNT_W     32  width of instr_count; wraps modulo 2**CNT_W
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  opcode         in   OPCODE_W  instr[31:26], valid from DECODE onward (IR loaded in FETCH)
//  zero           in   1      ALU zero flag, sampled in BRANCH
//  mem_ready      in   1      memory completes current access this cycle
//  mem_req        out  1      memory access request (FETCH/MEMRD/MEMWR)
//  iord           out  1      0=PC address, 1=ALUOut address
//  mem_write      out  1      memory write strobe
//  ir_write       out  1      instruction register load
//  pc_en          out  1      PC load = pc_write | (branch & zero)
//  pc_src         out  2      00=ALUResult 01=ALUOut 10=jump target
//  alu_src_a      out  1      0=PC 1=A
//  alu_src_b      out  2      00=B 01=const 4 10=SignImm 11=SignImm<<2
//  alu_operation  out  2      00=add 01=sub 10=by funct
//  reg_dst        out  1      0=rt 1=rd
//  mem_to_reg     out  1      0=ALUOut 1=Data
//  reg_write      out  1      register file write strobe
//  retire         out  1      one-cycle pulse when an instruction completes
//  instr_count    out  CNT_W  retired-instruction count
//  illegal_op     out  1      sticky; set on unsupported opcode
// BEHAVIOUR
//  - State reg 4 bits; all outputs decoded from state (Moore) except mem-gated strobes and pc_en.
//  - Reset: state<=FETCH, instr_count<=0, illegal_op<=0; while reset=1 all strobes (mem_req, mem_write, ir_write,
//    pc_en, reg_write, retire) forced 0, all selects 0. Reset mid-instruction abandons it; no retire.
//  - Unlisted outputs 0. FETCH: mem_req, src_b=01, op=00; ir_write & pc_en only when mem_ready; hold until mem_ready.
//  - DECODE: src_b=11, op=00. Next by opcode: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH,
//    000010->JUMP, 001000->ADDIEX (MC_ADDI_EN only), else TRAP.
//  - MEMADR: src_a=1, src_b=10 -> lw MEMRD, sw MEMWR.  MEMRD: mem_req, iord; wait mem_ready -> MEMWB.
//  - MEMWB: mem_to_reg=1, reg_write, retire -> FETCH.  MEMWR: mem_req, iord, mem_write gated by mem_ready;
//    retire on mem_ready -> FETCH.
//  - EXECUTE: src_a=1, op=10 -> ALUWB.  ALUWB: reg_dst=1, reg_write, retire -> FETCH.
//  - BRANCH: src_a=1, op=01, pc_src=01, pc_en=zero, retire -> FETCH.  JUMP: pc_src=10, pc_en, retire -> FETCH.
//  - TRAP: illegal_op<=1, all strobes 0, no retire; remains until reset.
//  - instr_count += 1 on every retire; wraps all-ones -> 0 silently.
//  - Latency (mem_ready tied 1): R=4, lw=5, sw=4, beq=3, j=3, addi=4 cycles.
// CONFIGURATION
//  MC_ADDI_EN defined: ADDIEX (src_a=1, src_b=10, op=00) -> ADDIWB (reg_dst=0, mem_to_reg=0, reg_write, retire).
//  Undefined: opcode 001000 decodes to TRAP; ADDI states absent from encoding.
// STRUCTURE
//  Package mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), alu_operation
//  enum (ALUOP_ADD/SUB/FUNCT), pc_src/alu_src_b encodings, state_t enum.
//  One sub-module mc_next_state: combinational next-state function (state, opcode, mem_ready -> next).
//  Top holds state reg, output decode, counter, illegal_op.
// TESTING
//  1 reset held 3 cycles mid-MEMRD -> all strobes 0, state FETCH, instr_count=0 after release.
//  2 opcode 000000, mem_ready=1 -> ALUWB in cycle 4 with reg_dst=1, reg_write=1, alu_operation=10 in EXECUTE; count=1.
//  3 lw with mem_ready low 3 cycles in MEMRD -> state holds, mem_req=1 throughout, MEMWB follows ready; latency 8.
//  4 beq zero=1 -> pc_en=1, pc_src=01; beq zero=0 -> pc_en=0; both retire.
//  5 opcode 111111 -> TRAP, illegal_op=1 sticky, retire never pulses, cleared only by reset.
//  6 001000 with/without MC_ADDI_EN -> ADDIWB reg_write, count+1 / TRAP; preload count 2**CNT_W-1 -> wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU operation, datapath selects, FSM states.
// MC_ADDI_EN adds the ADDIEX/ADDIWB states to the state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_TRAP    = 4'd10
`ifdef MC_ADDI_EN
    ,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12
`endif
  } state_t;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the multicycle controller (state, opcode, mem_ready -> next).
// MC_ADDI_EN routes opcode 001000 to ADDIEX instead of TRAP.
module mc_next_state
  import mips_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output state_t              next
);

  // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    next = state;
    case (state)
      S_FETCH:   if (mem_ready) next = S_DECODE;
      S_DECODE: begin
        if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) next = S_MEMADR;
        else if (opcode == OPCODE_W'(OP_RTYPE))                       next = S_EXECUTE;
        else if (opcode == OPCODE_W'(OP_BEQ))                         next = S_BRANCH;
        else if (opcode == OPCODE_W'(OP_J))                           next = S_JUMP;
`ifdef MC_ADDI_EN
        else if (opcode == OPCODE_W'(OP_ADDI))                        next = S_ADDIEX;
`endif
        else                                                          next = S_TRAP;
      end
      S_MEMADR:  next = (opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) next = S_MEMWB;
      S_MEMWR:   if (mem_ready) next = S_FETCH;
      S_EXECUTE: next = S_ALUWB;
`ifdef MC_ADDI_EN
      S_ADDIEX:  next = S_ADDIWB;
      S_ADDIWB:  next = S_FETCH;
`endif
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: next = S_FETCH;
      S_TRAP:    next = S_TRAP;
      default:   next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM with memory handshake, retire counter and sticky illegal-opcode trap.
// Define MC_ADDI_EN to support addi (ADDIEX/ADDIWB); otherwise 001000 traps.
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_operation,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic                illegal_op
);

  state_t state;
  state_t next;

  mc_next_state #(.OPCODE_W(OPCODE_W)) u_next_state (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .next      (next)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Outputs are forced quiet while reset is asserted, even before the state register has been cleared.
  always_comb begin
    mem_req       = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_operation = ALUOP_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE:  alu_src_b = SRCB_IMM_SH;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          retire     = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = mem_ready;
          retire    = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a     = 1'b1;
          alu_operation = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_operation = ALUOP_SUB;
          pc_src        = PCSRC_ALUOUT;
          pc_en         = zero;
          retire        = 1'b1;
        end
        S_JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
          retire = 1'b1;
        end
`ifdef MC_ADDI_EN
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)                 illegal_op <= 1'b0;
    else if (state == S_TRAP)  illegal_op <= 1'b1;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; a queue of expected retire events is matched against each observed retire.
// Honours MC_ADDI_EN when forming the addi expectation.
module tb_mc_control_fsm;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b, alu_operation;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, retire, illegal_op;
  logic [3:0] instr_count;

  typedef struct {
    int         lat;
    logic [3:0] cnt;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_write;
    logic       pc_en;
    logic [1:0] pc_src;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errors  = 0;
  logic [3:0] model_count = 4'd0;

  always #5 clk = ~clk;

  mc_control_fsm #(.OPCODE_W(6), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .iord          (iord),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_operation (alu_operation),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .retire        (retire),
    .instr_count   (instr_count),
    .illegal_op    (illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [5:0] op, input logic z, input int lat);
    exp_t e;
    e = '{lat: lat, cnt: model_count + 4'd1, reg_write: 1'b0, reg_dst: 1'b0,
          mem_to_reg: 1'b0, mem_write: 1'b0, pc_en: 1'b0, pc_src: 2'b00};
    case (op)
      T_RTYPE: begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      T_LW:    begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      T_SW:    e.mem_write = 1'b1;
      T_BEQ:   begin e.pc_en = z; e.pc_src = 2'b01; end
      T_J:     begin e.pc_en = 1'b1; e.pc_src = 2'b10; end
      T_ADDI:  e.reg_write = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Start in a FETCH cycle at posedge+1; return at posedge+1 of the following FETCH.
  task automatic exec(input logic [5:0] op, input logic z, input int stall_at, input int stalls,
                      input int lat, input string tag);
    exp_t e;
    int   seen_lat = 0;
    bit   done = 0;
    sb.push_back(expect_for(op, z, lat));
    opcode = op;
    zero   = z;
    for (int c = 1; c <= 40 && !done; c++) begin
      mem_ready = !(c >= stall_at && c < stall_at + stalls);
      @(negedge clk);
      if (c == 1) check({tag, "_fetch"}, {mem_req, ir_write, pc_en, alu_src_b}, 5'b11101);
      if (op == T_RTYPE && c == 3) check({tag, "_exec_aluop"}, {alu_src_a, alu_operation}, 3'b110);
      if (c >= stall_at && c < stall_at + stalls)
        check({tag, "_stall"}, {mem_req, iord, reg_write, retire}, 4'b1100);
      if (retire) begin
        seen_lat = c;
        done = 1;
        e = sb.pop_front();
        check({tag, "_latency"}, seen_lat, e.lat);
        check({tag, "_strobes"}, {reg_write, reg_dst, mem_to_reg, mem_write, pc_en, pc_src},
              {e.reg_write, e.reg_dst, e.mem_to_reg, e.mem_write, e.pc_en, e.pc_src});
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      e = sb.pop_front();
      check({tag, "_timeout"}, seen_lat, e.lat);
    end else begin
      check({tag, "_count"}, instr_count, e.cnt);
      model_count = e.cnt;
    end
  endtask

  // Hold reset for n cycles checking the quiet outputs, then leave the DUT in FETCH.
  task automatic do_reset(input int n, input string tag);
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_strobes"}, {mem_req, mem_write, ir_write, pc_en, reg_write, retire}, 6'b0);
      check({tag, "_selects"}, {iord, pc_src, alu_src_a, alu_src_b, alu_operation, reg_dst, mem_to_reg}, 11'b0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    model_count = 4'd0;
    #1;
    check({tag, "_fetch_after"}, {mem_req, ir_write, alu_src_b}, 4'b1001);
    check({tag, "_count"}, instr_count, 4'd0);
    check({tag, "_illegal"}, illegal_op, 1'b0);
  endtask

  // Unsupported opcode: no retire ever, illegal_op sticks even after the opcode changes.
  task automatic trap_check(input logic [5:0] op, input string tag);
    int retires = 0;
    opcode = op;
    mem_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 5) opcode = T_RTYPE;
      @(negedge clk);
      if (c == 1) check({tag, "_clear_before"}, illegal_op, 1'b0);
      if (retire) retires++;
      @(posedge clk); #1;
    end
    check({tag, "_no_retire"}, retires, 0);
    check({tag, "_illegal"}, illegal_op, 1'b1);
    check({tag, "_quiet"}, {mem_req, reg_write, pc_en, ir_write}, 4'b0);
    check({tag, "_count_held"}, instr_count, model_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    opcode = T_RTYPE;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(3, "init_reset");

    exec(T_RTYPE, 1'b0, 99, 0, 4, "rtype");
    exec(T_LW,    1'b0, 4,  3, 8, "lw_stall");
    exec(T_SW,    1'b0, 99, 0, 4, "sw");
    exec(T_BEQ,   1'b1, 99, 0, 3, "beq_taken");
    exec(T_BEQ,   1'b0, 99, 0, 3, "beq_not");

    // Abandon a load stalled in MEMRD with a 3-cycle reset.
    opcode = T_LW;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c < 4);
      @(negedge clk);
      if (c == 4) check("memrd_hold", {mem_req, iord}, 2'b11);
      @(posedge clk); #1;
    end
    do_reset(3, "mid_memrd_reset");

    for (int i = 0; i < 15; i++) exec(T_J, 1'b0, 99, 0, 3, "jump");
    check("pre_wrap", instr_count, 4'hf);
    exec(T_J, 1'b0, 99, 0, 3, "jump_wrap");
    check("wrapped", instr_count, 4'h0);

`ifdef MC_ADDI_EN
    exec(T_ADDI, 1'b0, 99, 0, 4, "addi");
`else
    trap_check(T_ADDI, "addi_trap");
    do_reset(1, "addi_reset");
`endif

    trap_check(T_BAD, "bad_op");
    do_reset(2, "trap_reset");
    exec(T_RTYPE, 1'b0, 99, 0, 4, "rtype_after_trap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
